// File: rtl/ama_appr4_add32_lsb8.sv
// Registered 32-bit approximate ripple-carry adder.
// Bits 0..7 use the Approximate Mirror Adder type 4 (AMA4) cell.
// Bits 8..31 use exact full adders.
// Sum and carry-out are captured in output registers with a synchronous active-high reset.
module ama_appr4_add32_lsb8 (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout
);

  // AMA4 cell, returned as {cout, s}.
  // The carry-out is simply the A input, so the carry chain through the
  // low byte is broken and the carry into bit 8 is exactly A[7].
  function automatic logic [1:0] ama4_cell(input logic a, input logic b, input logic c);
    logic s_v;
    s_v = (~a & b) | (a & b & c);
    return {a, s_v};
  endfunction

  // Exact full-adder cell, returned as {cout, s}.
  function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic c);
    logic s_v;
    logic co_v;
    s_v  = a ^ b ^ c;
    co_v = (a & b) | (c & (a ^ b));
    return {co_v, s_v};
  endfunction

  logic [31:0] w_sum;
  logic        w_carry;
  logic [1:0]  w_cell;
  logic [31:0] r_sum;
  logic        r_cout;

  // Per-cell ripple chain: AMA4 cells on the low byte, exact full adders above.
  always_comb begin
    w_sum   = 32'h0000_0000;
    w_carry = Cin;
    w_cell  = 2'b00;
    for (int i = 0; i < 8; i++) begin
      w_cell   = ama4_cell(A[i], B[i], w_carry);
      w_sum[i] = w_cell[0];
      w_carry  = w_cell[1];
    end
    for (int i = 8; i < 32; i++) begin
      w_cell   = fa_cell(A[i], B[i], w_carry);
      w_sum[i] = w_cell[0];
      w_carry  = w_cell[1];
    end
  end

  // Output registers; reset has priority and clears any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum  <= 32'h0000_0000;
      r_cout <= 1'b0;
    end else begin
      r_sum  <= w_sum;
      r_cout <= w_carry;
    end
  end

  assign S    = r_sum;
  assign Cout = r_cout;

endmodule

// File: tb/tb_ama_appr4_add32_lsb8.sv
// Self-checking bench for ama_appr4_add32_lsb8: directed vectors from the
// test plan, reset behaviour, and a randomized sweep against a reference model.
module tb_ama_appr4_add32_lsb8;

  logic        clk;
  logic        rst;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] S;
  logic        Cout;

  int checks;
  int errors;

  ama_appr4_add32_lsb8 dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the low byte is looked up from the AMA4 truth table
  // (carry into cell i is Cin for i=0, else A[i-1]); the upper 24 bits are a
  // plain integer sum of A[31:8] + B[31:8] + A[7]. Returns {Cout, S}.
  function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic [7:0]  tbl;
    logic [7:0]  lo;
    logic [24:0] hi;
    logic        c;
    tbl = 8'b1000_1100;
    lo  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      c     = (i == 0) ? cin : a[i-1];
      lo[i] = tbl[{a[i], b[i], c}];
    end
    hi = {1'b0, a[31:8]} + {1'b0, b[31:8]} + {24'h0, a[7]};
    return {hi, lo};
  endfunction

  // Drive one input set half a cycle before the edge, then sample 1 time unit after it.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic r);
    @(negedge clk);
    A   = a;
    B   = b;
    Cin = cin;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] exp_s, input logic exp_c);
    checks++;
    assert (S === exp_s) else begin
      errors++;
      $error("FAIL %s S: observed %h expected %h", tag, S, exp_s);
    end
    checks++;
    assert (Cout === exp_c) else begin
      errors++;
      $error("FAIL %s Cout: observed %b expected %b", tag, Cout, exp_c);
    end
  endtask

  initial begin
    logic [32:0] exp;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rc;
    longint      err;
    real         sum_e;
    real         sumsq_e;
    real         mean_e;
    real         var_e;
    int          n;

    checks = 0;
    errors = 0;
    A = 32'h0; B = 32'h0; Cin = 1'b0; rst = 1'b1;

    // Reset holds outputs at zero for two edges despite all-ones inputs
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("reset_edge1", 32'h0000_0000, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
    check("reset_edge2", 32'h0000_0000, 1'b0);
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    check("post_reset_ones", 32'hFFFF_FFFF, 1'b1);

    // Directed vectors from the test plan
    apply(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    check("exact_low_byte", 32'h0000_0100, 1'b0);
    apply(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
    check("err_cin_only", 32'h0000_0000, 1'b0);
    apply(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0);
    check("err_a1", 32'h0000_0000, 1'b0);
    apply(32'h0000_0000, 32'h0000_00FF, 1'b0, 1'b0);
    check("b_ff_exact", 32'h0000_00FF, 1'b0);
    apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    check("wrap_around", 32'h0000_0000, 1'b1);
    apply(32'h1234_5600, 32'h1111_1100, 1'b0, 1'b0);
    check("upper_exact", 32'h2345_6700, 1'b0);
    // Carry into bit 8 comes only from A[7], not B[7]
    apply(32'h0000_0000, 32'h0000_0080, 1'b0, 1'b0);
    check("b7_no_carry", 32'h0000_0080, 1'b0);
    apply(32'h0000_0080, 32'h0000_0000, 1'b0, 1'b0);
    check("a7_carry", 32'h0000_0100, 1'b0);

    // Mid-stream reset discards the in-flight result
    apply(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1);
    check("midstream_reset", 32'h0000_0000, 1'b0);
    apply(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    check("first_after_reset", 32'h0000_0000, 1'b1);

    // Full-width random vectors against the model
    for (int k = 0; k < 200; k++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      exp = model(ra, rb, rc);
      apply(ra, rb, rc, 1'b0);
      check("rand32", exp[31:0], exp[32]);
    end

    // Sweep over [0, 8191] with error statistics
    sum_e = 0.0;
    sumsq_e = 0.0;
    n = 10000;
    for (int k = 0; k < n; k++) begin
      ra = 32'($urandom_range(8191, 0));
      rb = 32'($urandom_range(8191, 0));
      exp = model(ra, rb, 1'b0);
      apply(ra, rb, 1'b0, 1'b0);
      check("sweep", exp[31:0], exp[32]);
      err = longint'({Cout, S}) - (longint'(ra) + longint'(rb));
      checks++;
      assert (err >= -256 && err <= 255) else begin
        errors++;
        $error("FAIL sweep_err_range: observed %0d expected within [-256,255]", err);
      end
      sum_e   = sum_e + real'(err);
      sumsq_e = sumsq_e + real'(err) * real'(err);
    end
    mean_e = sum_e / real'(n);
    var_e  = sumsq_e / real'(n) - mean_e * mean_e;
    $display("Sweep error statistics: mean %f variance %f over %0d vectors", mean_e, var_e, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
